// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART byte buffer / send sequencer:
//   - default byte width and FIFO address width
//   - transmit sequencer state encoding
//   - helper that derives the FIFO depth from its address width
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  // Sequencer states. WAIT holds until the transmitter reports the stop bit
  // is finished; there is deliberately no timeout.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

  // The FIFO relies on natural pointer wrap, so its depth is always a power
  // of two tied to the pointer width.
  function automatic int depth_from_addr(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Bundles the receive-side write strobe, the transmitter handshake and the
// FIFO status flags of uart_tx_fifo.
//   Wr_En / Wr_Data   : byte write strobe from the receiver (Rx_Done)
//   Tx_Done / Tx_State: transmitter end-of-stop-bit pulse and busy flag
//   Send_En / Data_Byte: start pulse and byte towards the transmitter
//   Full / Empty / Count / Overflow: FIFO status
// Modports:
//   master : environment side (receiver + transmitter)
//   slave  : the buffer / sequencer itself
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              Wr_En;
  logic [DATA_W-1:0] Wr_Data;
  logic              Tx_Done;
  logic              Tx_State;
  logic              Send_En;
  logic [DATA_W-1:0] Data_Byte;
  logic              Full;
  logic              Empty;
  logic [ADDR_W:0]   Count;
  logic              Overflow;

  modport master (
    output Wr_En,
    output Wr_Data,
    output Tx_Done,
    output Tx_State,
    input  Send_En,
    input  Data_Byte,
    input  Full,
    input  Empty,
    input  Count,
    input  Overflow
  );

  modport slave (
    input  Wr_En,
    input  Wr_Data,
    input  Tx_Done,
    input  Tx_State,
    output Send_En,
    output Data_Byte,
    output Full,
    output Empty,
    output Count,
    output Overflow
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock byte FIFO with occupancy counter and overflow pulse.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   wr_en    : write strobe
//   wr_data  : byte to store
//   rd_en    : pop strobe (ignored when empty)
//   rd_data  : current head byte (mem[rd_ptr], combinational view)
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
//   overflow : one-cycle pulse after a write was dropped
// ---------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = depth_from_addr(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              wr_ok;
  logic              rd_ok;

  // A write into a full FIFO is still accepted when a pop frees a slot in
  // the same cycle. Pointers wrap naturally because DEPTH == 2**ADDR_W.
  always_comb begin
    rd_ok      = rd_en && (count_q != '0);
    wr_ok      = wr_en && ((count_q != DEPTH_CNT) || rd_ok);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = wr_en && !wr_ok;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data  = mem[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == DEPTH_CNT);
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffers bytes from the UART receiver and hands them to the UART
// transmitter one at a time, so receive bursts that outrun transmission
// are not lost.
//   CLK : system clock, rising edge
//   RST : asynchronous active-low reset (shared with the transmitter)
//   bus : uart_tx_fifo_if.slave
//         Wr_En/Wr_Data in, Tx_Done/Tx_State in,
//         Send_En/Data_Byte out, Full/Empty/Count/Overflow out
// All outputs are registered.
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = depth_from_addr(ADDR_W)
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_fifo_if.slave  bus
);

  tx_state_e         state_q, state_d;
  logic              send_en_q, send_en_d;
  logic [DATA_W-1:0] data_byte_q, data_byte_d;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST),
    .wr_en    (bus.Wr_En),
    .wr_data  (bus.Wr_Data),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .count    (bus.Count),
    .full     (bus.Full),
    .empty    (fifo_empty),
    .overflow (bus.Overflow)
  );

  // The pop and the Send_En/Data_Byte capture happen on the same edge, so
  // Send_En rises in the SEND cycle with the popped byte already in place.
  // Data_Byte then holds until the next pop. Tx_Done is only looked at in
  // WAIT, so a stray pulse elsewhere has no effect.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    send_en_d   = 1'b0;
    data_byte_d = data_byte_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.Tx_State) begin
          pop         = 1'b1;
          send_en_d   = 1'b1;
          data_byte_d = fifo_head;
          state_d     = SEND;
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.Tx_Done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      send_en_q   <= 1'b0;
      data_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      send_en_q   <= send_en_d;
      data_byte_q <= data_byte_d;
    end
  end

  assign bus.Send_En   = send_en_q;
  assign bus.Data_Byte = data_byte_q;
  assign bus.Empty     = fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. Bytes written are queued as
// expectations; a transmitter model consumes them on each Send_En and
// answers with Tx_Done after a programmable delay.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic CLK;
  logic RST;

  uart_tx_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sbQueue[$];
  int         txDelay = 1;
  int         txTimer = 0;
  int         sendCount = 0;
  int         cycleCount = 0;
  int         lastDoneCycle = 0;
  bit         txBusy = 0;
  bit         txHold = 0;
  bit         haveDone = 0;
  bit         checkGap = 0;

  assign bus.Tx_State = txBusy | txHold;

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Counts one comparison and reports it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance n cycles, landing 1 time unit after the rising edge
  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One-cycle write strobe; the byte is expected at the output unless the
  // FIFO should drop it. Overflow is checked on the following cycle.
  task automatic applyStimulus(input logic [7:0] data, input bit expectDrop);
    bus.Wr_En   = 1'b1;
    bus.Wr_Data = data;
    if (!expectDrop) sbQueue.push_back(data);
    @(posedge CLK);
    #1;
    bus.Wr_En = 1'b0;
    checkOutput("overflow", 32'(bus.Overflow), 32'(expectDrop));
  endtask

  // Wait until every expected byte has been sent and the handshake is over
  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sbQueue.size() != 0 || txBusy || bus.Empty !== 1'b1 ||
            bus.Send_En === 1'b1) && n < budget) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput("drain_in_budget", 32'(n < budget), 32'd1);
    waitCycles(2);
  endtask

  // Transmitter model: scoreboard check on each Send_En, Tx_Done after txDelay
  initial begin
    bus.Tx_Done = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      cycleCount++;
      if (!RST) begin
        txBusy      = 1'b0;
        txTimer     = 0;
        bus.Tx_Done = 1'b0;
      end else begin
        bus.Tx_Done = 1'b0;
        if (txTimer > 0) begin
          txTimer--;
          if (txTimer == 0) begin
            bus.Tx_Done   = 1'b1;
            txBusy        = 1'b0;
            lastDoneCycle = cycleCount;
            haveDone      = 1'b1;
          end
        end
        if (bus.Send_En === 1'b1) begin
          sendCount++;
          if (checkGap && haveDone)
            checkOutput("send_gap", 32'(cycleCount - lastDoneCycle), 32'd2);
          checkOutput("sb_nonempty", 32'(sbQueue.size() > 0), 32'd1);
          if (sbQueue.size() > 0)
            checkOutput("data_byte", 32'(bus.Data_Byte), 32'(sbQueue.pop_front()));
          txBusy  = 1'b1;
          txTimer = txDelay;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence
  initial begin
    RST         = 1'b0;
    bus.Wr_En   = 1'b0;
    bus.Wr_Data = '0;
    repeat (3) @(posedge CLK);
    #1;

    // Reset values
    checkOutput("rst_count",     32'(bus.Count),     32'd0);
    checkOutput("rst_empty",     32'(bus.Empty),     32'd1);
    checkOutput("rst_full",      32'(bus.Full),      32'd0);
    checkOutput("rst_send_en",   32'(bus.Send_En),   32'd0);
    checkOutput("rst_data_byte", 32'(bus.Data_Byte), 32'd0);
    checkOutput("rst_overflow",  32'(bus.Overflow),  32'd0);
    RST = 1'b1;
    waitCycles(2);

    // Single byte latency: write in N, Count=1 in N+1, Send_En in N+2
    $display("[TB] single byte latency");
    txDelay   = 20;
    sendCount = 0;
    applyStimulus(8'hA5, 1'b0);
    checkOutput("lat_count_n1",   32'(bus.Count),   32'd1);
    checkOutput("lat_empty_n1",   32'(bus.Empty),   32'd0);
    checkOutput("lat_send_en_n1", 32'(bus.Send_En), 32'd0);
    waitCycles(1);
    checkOutput("lat_send_en_n2", 32'(bus.Send_En),   32'd1);
    checkOutput("lat_data_n2",    32'(bus.Data_Byte), 32'hA5);
    checkOutput("lat_count_n2",   32'(bus.Count),     32'd0);
    waitDrain(200);
    checkOutput("t1_send_count", 32'(sendCount), 32'd1);

    // Back-to-back writes with a slow transmitter
    $display("[TB] burst of five with slow transmitter");
    txDelay   = 100;
    sendCount = 0;
    haveDone  = 1'b0;
    checkGap  = 1'b1;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b0);
    waitDrain(1000);
    checkGap = 1'b0;
    checkOutput("t2_send_count", 32'(sendCount), 32'd5);

    // Fill to full while the transmitter is busy, then overflow
    $display("[TB] fill and overflow");
    txHold    = 1'b1;
    txDelay   = 3;
    sendCount = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'h40 + 8'(i), (i == 16));
      if (i == 14) checkOutput("full_at_15", 32'(bus.Full), 32'd0);
      if (i == 15) begin
        checkOutput("full_at_16",  32'(bus.Full),  32'd1);
        checkOutput("count_at_16", 32'(bus.Count), 32'd16);
      end
    end
    checkOutput("count_after_drop", 32'(bus.Count), 32'd16);
    waitCycles(1);
    checkOutput("overflow_one_cycle", 32'(bus.Overflow), 32'd0);
    checkOutput("count_held",         32'(bus.Count),    32'd16);
    txHold = 1'b0;
    waitDrain(500);
    checkOutput("t3_send_count", 32'(sendCount), 32'd16);

    // Write and pop in the same cycle with one byte queued
    $display("[TB] simultaneous write and pop");
    txHold    = 1'b1;
    sendCount = 0;
    applyStimulus(8'h11, 1'b0);
    checkOutput("t4_count_pre", 32'(bus.Count), 32'd1);
    txHold = 1'b0;
    applyStimulus(8'h3C, 1'b0);
    checkOutput("t4_count_same", 32'(bus.Count),     32'd1);
    checkOutput("t4_send_en",    32'(bus.Send_En),   32'd1);
    checkOutput("t4_old_head",   32'(bus.Data_Byte), 32'h11);
    waitDrain(200);
    checkOutput("t4_send_count", 32'(sendCount), 32'd2);

    // Pointer wrap: more than 2*DEPTH bytes with immediate Tx_Done
    $display("[TB] pointer wrap");
    txDelay   = 1;
    sendCount = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b0);
      waitCycles(3);
    end
    waitDrain(500);
    checkOutput("t5_send_count", 32'(sendCount), 32'd40);

    // Reset while waiting for Tx_Done with three bytes queued
    $display("[TB] reset mid transfer");
    txDelay   = 100;
    sendCount = 0;
    for (int i = 0; i < 4; i++) applyStimulus(8'hC0 + 8'(i), 1'b0);
    waitCycles(4);
    checkOutput("t6_count_pre", 32'(bus.Count),   32'd3);
    checkOutput("t6_in_wait",   32'(bus.Send_En), 32'd0);
    RST = 1'b0;
    #1;
    checkOutput("t6_rst_count",     32'(bus.Count),     32'd0);
    checkOutput("t6_rst_empty",     32'(bus.Empty),     32'd1);
    checkOutput("t6_rst_full",      32'(bus.Full),      32'd0);
    checkOutput("t6_rst_send_en",   32'(bus.Send_En),   32'd0);
    checkOutput("t6_rst_data_byte", 32'(bus.Data_Byte), 32'd0);
    sbQueue.delete();
    waitCycles(2);
    RST       = 1'b1;
    sendCount = 0;
    waitCycles(20);
    checkOutput("t6_no_send", 32'(sendCount), 32'd0);
    checkOutput("t6_empty",   32'(bus.Empty), 32'd1);
    applyStimulus(8'h77, 1'b0);
    waitDrain(300);
    checkOutput("t6_send_count", 32'(sendCount), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
